// File: rtl/mem_arb_pkg.sv
// Shared definitions for the IF/MEM unified-memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_D  = 1'b1;

  localparam int MEM_LAT_DEF    = 1;
  localparam int STARVE_MAX_DEF = 3;

endpackage

// File: rtl/mem_lat_timer.sv
// 4-bit load/decrement counter that tracks the remaining memory latency.
module mem_lat_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic       zero
);

  logic [3:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 4'd0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != 4'd0)) begin
      count <= count - 4'd1;
    end
  end

  assign zero = (count == 4'd0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and data access.
// Optional performance counters are built when ARB_PERF_CNT_EN is defined.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int MEM_LAT    = MEM_LAT_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic              d_byte,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_byte,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_if,
  output logic              stall_mem
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]       perf_if_stall,
  output logic [31:0]       perf_mem_stall,
  output logic [31:0]       perf_forced
`endif
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  localparam logic [3:0] LAT_LOAD   = 4'(MEM_LAT - 1);

  state_t     state, state_nxt;
  logic [3:0] starve_cnt;
  logic       owner;
  logic       owner_we;
  logic       decide, capture, timer_load, timer_dec, timer_zero;
  logic       starved, grant_d, forced;

  // IF only overrides data once it has lost STARVE_MAX decisions in a row.
  assign starved = (starve_cnt == STARVE_LIM);
  assign grant_d = d_req && !(if_req && starved);
  assign forced  = if_req && d_req && starved;

  assign stall_if  = if_req & ~if_done;
  assign stall_mem = d_req & ~d_done;

  mem_lat_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .load_val (LAT_LOAD),
    .dec      (timer_dec),
    .zero     (timer_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    decide     = 1'b0;
    capture    = 1'b0;
    timer_load = 1'b0;
    timer_dec  = 1'b0;
    case (state)
      IDLE: begin
        if (if_req || d_req) begin
          decide    = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        timer_load = 1'b1;
        state_nxt  = WAIT;
      end
      WAIT: begin
        if (timer_zero) begin
          capture   = 1'b1;
          state_nxt = DONE;
        end else begin
          timer_dec = 1'b1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Memory strobes are registered at the decision so they line up with ISSUE.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= 4'd0;
      owner      <= OWN_IF;
      owner_we   <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_byte   <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_done    <= 1'b0;
      d_done     <= 1'b0;
      if_rdata   <= '0;
      d_rdata    <= '0;
    end else begin
      mem_en   <= 1'b0;
      mem_we   <= 1'b0;
      mem_byte <= 1'b0;
      if_done  <= 1'b0;
      d_done   <= 1'b0;
      if (decide) begin
        mem_en <= 1'b1;
        if (grant_d) begin
          owner     <= OWN_D;
          owner_we  <= d_we;
          mem_addr  <= d_addr;
          mem_we    <= d_we;
          mem_byte  <= d_byte;
          mem_wdata <= d_wdata;
          if (if_req && !starved) starve_cnt <= starve_cnt + 4'd1;
        end else begin
          owner      <= OWN_IF;
          owner_we   <= 1'b0;
          mem_addr   <= if_addr << 2;
          starve_cnt <= 4'd0;
        end
      end
      if (capture) begin
        if (owner == OWN_IF) begin
          if_rdata <= mem_rdata;
          if_done  <= 1'b1;
        end else begin
          if (!owner_we) d_rdata <= mem_rdata;
          d_done <= 1'b1;
        end
      end
    end
  end

`ifdef ARB_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_if_stall  <= 32'd0;
      perf_mem_stall <= 32'd0;
      perf_forced    <= 32'd0;
    end else begin
      if (stall_if)         perf_if_stall  <= perf_if_stall + 32'd1;
      if (stall_mem)        perf_mem_stall <= perf_mem_stall + 32'd1;
      if (decide && forced) perf_forced    <= perf_forced + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: MEM_LAT=1 and MEM_LAT=4 instances.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        if_req, if_done, d_req, d_we, d_byte, d_done;
  logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata;
  logic        mem_en, mem_we, mem_byte, stall_if, stall_mem;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic        f4_if_req, f4_if_done, f4_d_done;
  logic [31:0] f4_if_addr, f4_if_rdata, f4_d_rdata;
  logic        f4_mem_en, f4_mem_we, f4_mem_byte, f4_stall_if, f4_stall_mem;
  logic [31:0] f4_mem_addr, f4_mem_wdata, f4_mem_rdata;

`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_if_stall, perf_mem_stall, perf_forced;
  logic [31:0] f4_perf_if_stall, f4_perf_mem_stall, f4_perf_forced;
`endif

  mem_port_arbiter #(.DATA_W(32), .ADDR_W(32), .MEM_LAT(1), .STARVE_MAX(3)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_byte(d_byte),
    .d_done(d_done), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_byte(mem_byte), .mem_rdata(mem_rdata),
    .stall_if(stall_if), .stall_mem(stall_mem)
`ifdef ARB_PERF_CNT_EN
    , .perf_if_stall(perf_if_stall), .perf_mem_stall(perf_mem_stall), .perf_forced(perf_forced)
`endif
  );

  mem_port_arbiter #(.DATA_W(32), .ADDR_W(32), .MEM_LAT(4), .STARVE_MAX(3)) dut4 (
    .clk(clk), .rst(rst),
    .if_req(f4_if_req), .if_addr(f4_if_addr), .if_done(f4_if_done), .if_rdata(f4_if_rdata),
    .d_req(1'b0), .d_we(1'b0), .d_addr(32'd0), .d_wdata(32'd0), .d_byte(1'b0),
    .d_done(f4_d_done), .d_rdata(f4_d_rdata),
    .mem_en(f4_mem_en), .mem_we(f4_mem_we), .mem_addr(f4_mem_addr), .mem_wdata(f4_mem_wdata),
    .mem_byte(f4_mem_byte), .mem_rdata(f4_mem_rdata),
    .stall_if(f4_stall_if), .stall_mem(f4_stall_mem)
`ifdef ARB_PERF_CNT_EN
    , .perf_if_stall(f4_perf_if_stall), .perf_mem_stall(f4_perf_mem_stall),
    .perf_forced(f4_perf_forced)
`endif
  );

  // Memory models: read data only becomes valid MEM_LAT cycles after mem_en.
  logic [31:0] mem1 [0:255];
  logic [31:0] mem4 [0:255];
  logic [7:0]  m1_idx, m4_idx;
  int          m1_age, m4_age;

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem1[i] = 32'd0;
      mem4[i] = 32'd0;
    end
    mem1[8'h10] = 32'h00A00093;
    mem4[8'h10] = 32'h00A00093;
    m1_idx = 8'd0; m4_idx = 8'd0; m1_age = 0; m4_age = 0;
  end

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem1[mem_addr[9:2]] <= mem_wdata;
      m1_idx <= mem_addr[9:2];
      m1_age <= 1;
    end else if (m1_age < 100) m1_age <= m1_age + 1;
    if (f4_mem_en) begin
      m4_idx <= f4_mem_addr[9:2];
      m4_age <= 1;
    end else if (m4_age < 100) m4_age <= m4_age + 1;
  end

  assign mem_rdata    = (m1_age >= 1) ? mem1[m1_idx] : 32'hBAD0BAD0;
  assign f4_mem_rdata = (m4_age >= 4) ? mem4[m4_idx] : 32'hBAD0BAD0;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        is_d;
    logic        we;
    logic        byt;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_maddr;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [6];

  // One complete transaction on the MEM_LAT=1 instance, checked end to end.
  task automatic apply_stimulus(input vec_t v, input int idx);
    int cyc, en_cnt, lat;
    logic [31:0] s_addr, s_wdata;
    logic s_we, s_byte, got, other;
    cyc = 0; en_cnt = 0; lat = -1; got = 1'b0; other = 1'b0;
    s_addr = 32'hFFFFFFFF; s_wdata = 32'hFFFFFFFF; s_we = 1'bx; s_byte = 1'bx;
    @(negedge clk);
    if (v.is_d) begin
      d_req = 1'b1; d_we = v.we; d_byte = v.byt; d_addr = v.addr; d_wdata = v.wdata;
    end else begin
      if_req = 1'b1; if_addr = v.addr;
    end
    while (!got && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (mem_en) begin
        en_cnt++; s_addr = mem_addr; s_we = mem_we; s_byte = mem_byte; s_wdata = mem_wdata;
      end
      if (v.is_d ? d_done : if_done) begin got = 1'b1; lat = cyc; end
      if (v.is_d ? if_done : d_done) other = 1'b1;
    end
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_byte = 1'b0;
    check_output($sformatf("v%0d_mem_en_count", idx), 32'(en_cnt), 32'd1);
    check_output($sformatf("v%0d_mem_addr", idx), s_addr, v.exp_maddr);
    check_output($sformatf("v%0d_mem_we", idx), {31'd0, s_we}, {31'd0, v.we});
    check_output($sformatf("v%0d_mem_byte", idx), {31'd0, s_byte}, {31'd0, v.byt});
    if (v.we) check_output($sformatf("v%0d_mem_wdata", idx), s_wdata, v.wdata);
    check_output($sformatf("v%0d_latency", idx), 32'(lat), 32'd3);
    check_output($sformatf("v%0d_other_done", idx), {31'd0, other}, 32'd0);
    check_output($sformatf("v%0d_rdata", idx), v.is_d ? d_rdata : if_rdata, v.exp_rdata);
    @(negedge clk);
    check_output($sformatf("v%0d_done_width", idx), {31'd0, (v.is_d ? d_done : if_done)}, 32'd0);
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int cyc, g, scnt, lat, en4;
    logic got, stall_at_done;
    logic [31:0] addr4;
    logic own [8];
    logic exp_own [8];

    // is_d we byt addr wdata exp_maddr exp_rdata
    vecs[0] = '{1'b0, 1'b0, 1'b0, 32'h10,  32'h0,        32'h40,  32'h00A00093};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 32'h100, 32'hDEADBEEF, 32'h100, 32'h00000000};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 32'h100, 32'h0,        32'h100, 32'hDEADBEEF};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 32'h40,  32'h0,        32'h100, 32'hDEADBEEF};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 32'h8,   32'h00000055, 32'h8,   32'hDEADBEEF};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 32'h8,   32'h0,        32'h8,   32'h00000055};
    exp_own = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

    rst = 1'b1;
    if_req = 1'b0; if_addr = 32'd0; d_req = 1'b0; d_we = 1'b0; d_addr = 32'd0;
    d_wdata = 32'd0; d_byte = 1'b0; f4_if_req = 1'b0; f4_if_addr = 32'd0;
    repeat (2) @(negedge clk);
    check_output("rst_if_done", {31'd0, if_done}, 32'd0);
    check_output("rst_d_done", {31'd0, d_done}, 32'd0);
    check_output("rst_mem_en", {31'd0, mem_en}, 32'd0);
    check_output("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check_output("rst_mem_byte", {31'd0, mem_byte}, 32'd0);
    check_output("rst_mem_addr", mem_addr, 32'd0);
    check_output("rst_mem_wdata", mem_wdata, 32'd0);
    check_output("rst_if_rdata", if_rdata, 32'd0);
    check_output("rst_d_rdata", d_rdata, 32'd0);
    check_output("rst_f4_mem_en", {31'd0, f4_mem_en}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) apply_stimulus(vecs[i], i);

    // Both requesters held: data wins three times, then IF is forced in.
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h10; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
    cyc = 0; g = 0;
    while (g < 8 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (mem_en) begin
        own[g] = (mem_addr == 32'h40) ? 1'b0 : 1'b1;
        g++;
      end
    end
    check_output("starve_grant_count", 32'(g), 32'd8);
    for (int k = 0; k < 8; k++)
      check_output($sformatf("starve_owner%0d", k), {31'd0, (k < g) ? own[k] : 1'bx},
                   {31'd0, exp_own[k]});
    got = 1'b0;
    while (!got && cyc < 220) begin
      @(negedge clk);
      cyc++;
      if (if_done) got = 1'b1;
    end
    if_req = 1'b0; d_req = 1'b0;
    check_output("starve_last_if_done", {31'd0, got}, 32'd1);
    check_output("starve_if_rdata", if_rdata, 32'h00A00093);
    check_output("starve_d_rdata", d_rdata, 32'hDEADBEEF);
`ifdef ARB_PERF_CNT_EN
    check_output("perf_forced", perf_forced, 32'd2);
`endif
    repeat (2) @(negedge clk);

    // Reset while a load sits in WAIT aborts it without a done pulse.
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h8;
    repeat (2) @(negedge clk);
    rst = 1'b1; d_req = 1'b0;
    @(negedge clk);
    check_output("abort_d_done", {31'd0, d_done}, 32'd0);
    check_output("abort_mem_en", {31'd0, mem_en}, 32'd0);
    check_output("abort_mem_addr", mem_addr, 32'd0);
    check_output("abort_d_rdata", d_rdata, 32'd0);
    check_output("abort_if_rdata", if_rdata, 32'd0);
    rst = 1'b0;
    g = 0;
    repeat (4) begin
      @(negedge clk);
      if (d_done || mem_en) g++;
    end
    check_output("abort_no_activity", 32'(g), 32'd0);
    apply_stimulus(vecs[2], 10);

    // MEM_LAT=4 fetch: done six cycles after the request, stalled meanwhile.
    @(negedge clk);
    f4_if_req = 1'b1; f4_if_addr = 32'h10;
    #1;
    cyc = 0; scnt = f4_stall_if ? 1 : 0; lat = -1; got = 1'b0; stall_at_done = 1'bx;
    en4 = 0; addr4 = 32'hFFFFFFFF;
    while (!got && cyc < 30) begin
      @(negedge clk);
      cyc++;
      if (f4_mem_en) begin en4++; addr4 = f4_mem_addr; end
      if (f4_if_done) begin got = 1'b1; lat = cyc; stall_at_done = f4_stall_if; end
      else if (f4_stall_if) scnt++;
    end
    f4_if_req = 1'b0;
    check_output("lat4_latency", 32'(lat), 32'd6);
    check_output("lat4_stall_cycles", 32'(scnt), 32'd6);
    check_output("lat4_stall_at_done", {31'd0, stall_at_done}, 32'd0);
    check_output("lat4_mem_en_count", 32'(en4), 32'd1);
    check_output("lat4_mem_addr", addr4, 32'h40);
    check_output("lat4_if_rdata", f4_if_rdata, 32'h00A00093);
    @(negedge clk);
    check_output("lat4_done_width", {31'd0, f4_if_done}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
